// File: rtl/vend_pkg.sv
// Shared constants for the parametrised vending controller: one-hot state
// encodings and coin values in half-units.
package vend_pkg;

  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_COLLECT = 4'b0010;
  localparam logic [3:0] S_VEND    = 4'b0100;
  localparam logic [3:0] S_PAYOUT  = 4'b1000;

  localparam logic [1:0] UNIT_HALF = 2'd1;
  localparam logic [1:0] UNIT_ONE  = 2'd2;

endpackage

// File: rtl/vend_payout.sv
// Payout stage: releases change one coin per ready cycle, largest coin first,
// and reports the decremented credit back to the controller.
module vend_payout
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                i_sysclk,
  input  logic                i_sysrst,
  input  logic                payout_en,
  input  logic                payout_rdy,
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] credit_nxt,
  output logic                payout_done,
  output logic                change_one,
  output logic                change_half
);

  logic take_one;
  logic take_half;

  always_comb begin
    take_one    = payout_en && payout_rdy && (credit >= CREDIT_W'(UNIT_ONE));
    take_half   = payout_en && payout_rdy && (credit == CREDIT_W'(UNIT_HALF));
    credit_nxt  = credit;
    if (take_one)
      credit_nxt = credit - CREDIT_W'(UNIT_ONE);
    else if (take_half)
      credit_nxt = credit - CREDIT_W'(UNIT_HALF);
    payout_done = payout_en && (credit_nxt == '0);
  end

  // Pulses land the cycle after the coin is taken from credit.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      change_one  <= 1'b0;
      change_half <= 1'b0;
    end else begin
      change_one  <= take_one;
      change_half <= take_half;
    end
  end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit accumulation, vend and refund FSM.
// Optional sales counter port enabled by defining VEND_SALES_CNT_EN.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 7
) (
  input  logic                i_sysclk,
  input  logic                i_sysrst,
  input  logic                i_money_half,
  input  logic                i_money_one,
  input  logic                i_cancel,
  input  logic                i_payout_rdy,
  output logic                o_cola,
  output logic                o_change_half,
  output logic                o_change_one,
  output logic                o_busy,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [3:0]          o_state
`ifdef VEND_SALES_CNT_EN
  ,
  output logic [15:0]         o_sales_cnt
`endif
);

  if (PRICE < 2 || PRICE > 63 || (PRICE + 2) > (2 ** CREDIT_W - 1)) begin : g_param_check
    $error("vend_fsm_param: PRICE out of 2..63 or CREDIT_W cannot hold PRICE+2");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  logic [3:0]          state;
  logic [3:0]          state_nxt;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] pay_credit_nxt;
  logic                pay_done;
  logic                coin_any;

  assign coin_any   = i_money_half | i_money_one;
  assign coin_add   = (i_money_half ? CREDIT_W'(UNIT_HALF) : '0)
                    + (i_money_one  ? CREDIT_W'(UNIT_ONE)  : '0);
  assign credit_sum = credit + coin_add;

  vend_payout #(
    .CREDIT_W (CREDIT_W)
  ) u_payout (
    .i_sysclk    (i_sysclk),
    .i_sysrst    (i_sysrst),
    .payout_en   (state == S_PAYOUT),
    .payout_rdy  (i_payout_rdy),
    .credit      (credit),
    .credit_nxt  (pay_credit_nxt),
    .payout_done (pay_done),
    .change_one  (o_change_one),
    .change_half (o_change_half)
  );

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    case (state)
      S_IDLE: begin
        if (coin_any) begin
          state_nxt  = S_COLLECT;
          credit_nxt = coin_add;
        end
      end
      S_COLLECT: begin
        // Cancel wins over reaching the price; the same-cycle coin is refunded too.
        credit_nxt = credit_sum;
        if (i_cancel)
          state_nxt = S_PAYOUT;
        else if (credit_sum >= PRICE_C)
          state_nxt = S_VEND;
      end
      S_VEND: begin
        credit_nxt = credit - PRICE_C;
        state_nxt  = (credit_nxt != '0) ? S_PAYOUT : S_IDLE;
      end
      S_PAYOUT: begin
        credit_nxt = pay_credit_nxt;
        if (pay_done)
          state_nxt = S_IDLE;
      end
      default: begin
        state_nxt  = S_IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state  <= S_IDLE;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  assign o_cola   = (state == S_VEND);
  assign o_busy   = (state == S_VEND) || (state == S_PAYOUT);
  assign o_credit = credit;
  assign o_state  = state;

`ifdef VEND_SALES_CNT_EN
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst)
      o_sales_cnt <= '0;
    else if ((state == S_VEND) && (o_sales_cnt != '1))
      o_sales_cnt <= o_sales_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: directed scenarios plus random purchases, with a
// queue of expected vend/change pulses checked by an independent monitor.
module tb_vend_fsm_param;

  localparam int PRICE    = 5;
  localparam int CREDIT_W = 7;
  localparam int EV_COLA  = 1;
  localparam int EV_ONE   = 2;
  localparam int EV_HALF  = 3;

  logic i_sysclk     = 1'b0;
  logic i_sysrst     = 1'b1;
  logic i_money_half = 1'b0;
  logic i_money_one  = 1'b0;
  logic i_cancel     = 1'b0;
  logic i_payout_rdy = 1'b0;
  logic o_cola;
  logic o_change_half;
  logic o_change_one;
  logic o_busy;
  logic [CREDIT_W-1:0] o_credit;
  logic [3:0]          o_state;
`ifdef VEND_SALES_CNT_EN
  logic [15:0]         o_sales_cnt;
`endif

  int checks    = 0;
  int errors    = 0;
  int exp_q[$];
  int rdy_mode  = 0;   // 0 random, 1 held low, 2 held high
  int exp_sales = 0;
  int mon_act;
  int mon_exp;

  vend_fsm_param #(
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .i_sysclk      (i_sysclk),
    .i_sysrst      (i_sysrst),
    .i_money_half  (i_money_half),
    .i_money_one   (i_money_one),
    .i_cancel      (i_cancel),
    .i_payout_rdy  (i_payout_rdy),
    .o_cola        (o_cola),
    .o_change_half (o_change_half),
    .o_change_one  (o_change_one),
    .o_busy        (o_busy),
    .o_credit      (o_credit),
    .o_state       (o_state)
`ifdef VEND_SALES_CNT_EN
    ,
    .o_sales_cnt   (o_sales_cnt)
`endif
  );

  always #5 i_sysclk = ~i_sysclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge i_sysclk);
    case (rdy_mode)
      1:       i_payout_rdy = 1'b0;
      2:       i_payout_rdy = 1'b1;
      default: i_payout_rdy = ($urandom_range(0, 2) != 0);
    endcase
  end

  always @(negedge i_sysclk) begin
    if (!i_sysrst && (o_cola || o_change_one || o_change_half)) begin
      mon_act = o_cola ? EV_COLA : (o_change_one ? EV_ONE : EV_HALF);
      chk("pulse_onehot", int'(o_cola) + int'(o_change_one) + int'(o_change_half), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%0d required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pulse_order", mon_act, mon_exp);
      end
    end
  end

  task automatic drive(input logic h, input logic o, input logic c);
    i_money_half = h;
    i_money_one  = o;
    i_cancel     = c;
    @(negedge i_sysclk);
    i_money_half = 1'b0;
    i_money_one  = 1'b0;
    i_cancel     = 1'b0;
  endtask

  task automatic push_refund(input int r);
    for (int i = 0; i < r / 2; i++) exp_q.push_back(EV_ONE);
    if (r % 2 != 0) exp_q.push_back(EV_HALF);
  endtask

  task automatic expect_sale(input int paid);
    exp_q.push_back(EV_COLA);
    exp_sales++;
    push_refund(paid - PRICE);
  endtask

  task automatic finish_txn(input string name);
    int n;
    n = 0;
    while (o_state != 4'b0001 && n < 300) begin
      @(negedge i_sysclk);
      n++;
    end
    chk({name, "_idle"}, int'(o_state), 1);
    repeat (2) @(negedge i_sysclk);
    chk({name, "_credit0"}, int'(o_credit), 0);
    chk({name, "_busy0"}, int'(o_busy), 0);
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
`ifdef VEND_SALES_CNT_EN
    chk({name, "_sales"}, int'(o_sales_cnt), exp_sales);
`endif
  endtask

  task automatic rand_txn();
    int  credit;
    int  v;
    bit  c;
    bit  first;
    bit  done;
    bit  sold;
    credit = 0;
    first  = 1'b1;
    done   = 1'b0;
    while (!done) begin
      v    = first ? $urandom_range(1, 3) : $urandom_range(0, 3);
      c    = ($urandom_range(0, 5) == 0);
      sold = 1'b0;
      credit += v;
      if (!first && c) begin
        push_refund(credit);
        done = 1'b1;
      end else if (credit >= PRICE) begin
        expect_sale(credit);
        sold = 1'b1;
        done = 1'b1;
      end
      drive(v[0], v[1], c);
      if (sold)
        chk("cola_timing", int'(o_cola), 1);
      else if (!done) begin
        chk("collect_credit", int'(o_credit), credit);
        chk("collect_state", int'(o_state), 2);
      end
      first = 1'b0;
    end
    finish_txn("rand");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_sysclk);
    chk("rst_state", int'(o_state), 1);
    chk("rst_credit", int'(o_credit), 0);
    chk("rst_outs", int'({o_cola, o_change_half, o_change_one, o_busy}), 0);
    i_sysrst = 1'b0;
    @(negedge i_sysclk);

    // Cancel while idle is ignored
    drive(1'b0, 1'b0, 1'b1);
    chk("idle_cancel_state", int'(o_state), 1);
    chk("idle_cancel_credit", int'(o_credit), 0);

    // Five half coins: exact price
    rdy_mode = 2;
    expect_sale(5);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    chk("t1_cola", int'(o_cola), 1);
    finish_txn("t1");

    // Three one coins: credit 6, half-unit change
    expect_sale(6);
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    chk("t2_cola", int'(o_cola), 1);
    finish_txn("t2");

    // Both coins together twice: 3 then 6
    drive(1'b1, 1'b1, 1'b0);
    chk("t3_credit3", int'(o_credit), 3);
    expect_sale(6);
    drive(1'b1, 1'b1, 1'b0);
    chk("t3_cola", int'(o_cola), 1);
    finish_txn("t3");

    // Cancel with payout stalled for three cycles
    rdy_mode = 1;
    repeat (2) @(negedge i_sysclk);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    push_refund(4);
    drive(1'b0, 1'b0, 1'b1);
    chk("t4_payout_state", int'(o_state), 8);
    chk("t4_busy", int'(o_busy), 1);
    repeat (3) begin
      @(negedge i_sysclk);
      chk("t4_stall_pulse", int'(o_change_one | o_change_half | o_cola), 0);
      chk("t4_stall_credit", int'(o_credit), 4);
    end
    rdy_mode = 2;
    finish_txn("t4");

    // Reset during payout with credit 3
    rdy_mode = 1;
    repeat (2) @(negedge i_sysclk);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("t5_pre_state", int'(o_state), 8);
    chk("t5_pre_credit", int'(o_credit), 3);
    #2;
    i_sysrst = 1'b1;
    #1;
    chk("t5_rst_state", int'(o_state), 1);
    chk("t5_rst_credit", int'(o_credit), 0);
    chk("t5_rst_outs", int'({o_cola, o_change_half, o_change_one, o_busy}), 0);
    exp_sales = 0;
    @(negedge i_sysclk);
    i_sysrst = 1'b0;
    rdy_mode = 0;
    finish_txn("t5");

    for (int t = 0; t < 40; t++) rand_txn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
